// File: rtl/nrf_ce_pkg.sv
// rtl/nrf_ce_pkg.sv - shared register map, bit indices and FSM encoding for the nRF CE pulse port
package nrf_ce_pkg;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_LEN   = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_DONE  = 2'd3;

    localparam int CTRL_MASK_BIT  = 0;
    localparam int CTRL_START_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } ce_state_t;

endpackage

// File: rtl/nrf_ce_pulse_timer.sv
// rtl/nrf_ce_pulse_timer.sv - loadable down-counter shared by the pulse and holdoff phases
module nrf_ce_pulse_timer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [LEN_W-1:0] count;

    // Saturates at zero so a stray enable can never wrap the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nrf_ce_pulse_out.sv
// rtl/nrf_ce_pulse_out.sv - Avalon-MM slave driving nRF24L01 CE with static level and timed pulse
module nrf_ce_pulse_out
    import nrf_ce_pkg::*;
#(
    parameter int          LEN_W       = 16,
    parameter int unsigned DEFAULT_LEN = 600,
    parameter int unsigned HOLDOFF     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        ce_out
);

    localparam logic [LEN_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? LEN_W'(HOLDOFF - 1) : '0;

    ce_state_t        state;
    logic             pulse_act;
    logic             level;
    logic             irq_mask;
    logic             done;
    logic [LEN_W-1:0] pulse_len;

    logic             wr_en;
    logic             wr_level;
    logic             wr_len;
    logic             wr_ctrl;
    logic             wr_done;
    logic             start_req;
    logic             busy;
    logic             tmr_zero;
    logic             tmr_load;
    logic             done_set;
    logic [LEN_W-1:0] tmr_val;
    logic [LEN_W-1:0] first_load;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign wr_level  = wr_en && (address == ADDR_LEVEL);
    assign wr_len    = wr_en && (address == ADDR_LEN);
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_done   = wr_en && (address == ADDR_DONE);
    assign start_req = wr_ctrl && writedata[CTRL_START_BIT];
    assign busy      = (state != ST_IDLE);
    assign done_set  = (state == ST_PULSE) && tmr_zero;
    assign irq       = done & irq_mask;

    assign unused_wdata = ^writedata;

    // A zero length still produces a one-cycle pulse.
    assign first_load = (pulse_len == '0) ? '0 : pulse_len - 1'b1;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;
        if ((state == ST_IDLE) && start_req) begin
            tmr_load = 1'b1;
            tmr_val  = first_load;
        end else if (done_set && (HOLDOFF != 0)) begin
            tmr_load = 1'b1;
        end
    end

    nrf_ce_pulse_timer #(
        .LEN_W (LEN_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (busy),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pulse_act <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_PULSE;
                        pulse_act <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero) begin
                        pulse_act <= 1'b0;
                        state     <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pulse_act <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_LEVEL: rd_next[0] = ce_out;
            ADDR_LEN:   rd_next    = 32'(pulse_len);
            ADDR_CTRL: begin
                rd_next[CTRL_MASK_BIT] = irq_mask;
                rd_next[CTRL_BUSY_BIT] = busy;
            end
            default:    rd_next[0] = done;
        endcase
    end

    // The done-set event takes priority over a software clear on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level     <= 1'b0;
            pulse_len <= LEN_W'(DEFAULT_LEN);
            irq_mask  <= 1'b0;
            done      <= 1'b0;
            ce_out    <= 1'b0;
            readdata  <= '0;
        end else begin
            if (wr_level) begin
                level <= writedata[0];
            end
            if (wr_len) begin
                pulse_len <= writedata[LEN_W-1:0];
            end
            if (wr_ctrl) begin
                irq_mask <= writedata[CTRL_MASK_BIT];
            end
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_done) begin
                done <= 1'b0;
            end
            ce_out   <= level | pulse_act;
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_nrf_ce_pulse_out.sv
// tb/tb_nrf_ce_pulse_out.sv - directed self-checking bench for nrf_ce_pulse_out
module tb_nrf_ce_pulse_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        ce_out;

    int n_cmp = 0;
    int n_err = 0;
    int ce_total = 0;
    int ce_base;
    logic [31:0] rv;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ce_out === 1'b1) ce_total <= ce_total + 1;
    end

    nrf_ce_pulse_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .ce_out     (ce_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", 32'(ce_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, rv); chk("rst_level", rv, 32'd0);
        rd(2'd1, rv); chk("rst_len", rv, 32'd600);
        rd(2'd2, rv); chk("rst_ctrl", rv, 32'd0);
        rd(2'd3, rv); chk("rst_done", rv, 32'd0);

        // Basic pulse: LEN=5, START at edge N; watch CE and busy edge by edge
        wr(2'd1, 32'd5);
        rd(2'd1, rv); chk("len_rb", rv, 32'd5);
        wr(2'd2, 32'h2);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("basic_ce_k%0d", k), 32'(ce_out), (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("basic_busy_k%0d", k), readdata, (k <= 9) ? 32'h2 : 32'h0);
        end
        rd(2'd3, rv); chk("basic_done", rv, 32'd1);
        chk("basic_irq_masked", 32'(irq), 32'd0);

        // IRQ with mask set
        wr(2'd3, 32'd0);
        rd(2'd3, rv); chk("done_clear", rv, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'h2, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_before_fall", 32'(irq), 32'd0);
        chk("irq_ce_high", 32'(ce_out), 32'd1);
        @(posedge clk);
        #1;
        chk("irq_after_fall", 32'(irq), 32'd1);
        repeat (6) @(posedge clk);
        rd(2'd2, rv); chk("mask_rb", rv, 32'h1);
        wr(2'd3, 32'd0);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr(2'd2, 32'h2);
        repeat (10) @(posedge clk);
        #1;
        chk("irq_masked_off", 32'(irq), 32'd0);
        rd(2'd3, rv); chk("done_while_masked", rv, 32'd1);
        rd(2'd2, rv); chk("ctrl_idle_nomask", rv, 32'd0);

        // START during PULSE and during HOLD is ignored
        wr(2'd1, 32'd5);
        ce_base = ce_total;
        wr(2'd2, 32'h2);
        wr(2'd2, 32'h2);
        repeat (4) @(posedge clk);
        wr(2'd2, 32'h2);
        repeat (20) @(posedge clk);
        chk("no_retrigger", 32'(ce_total - ce_base), 32'd5);

        // LEN write mid-pulse affects only the next pulse
        ce_base = ce_total;
        wr(2'd2, 32'h2);
        wr(2'd1, 32'd2);
        repeat (15) @(posedge clk);
        chk("len_busy_cur", 32'(ce_total - ce_base), 32'd5);
        ce_base = ce_total;
        wr(2'd2, 32'h2);
        repeat (12) @(posedge clk);
        chk("len_busy_next", 32'(ce_total - ce_base), 32'd2);

        // LEN=0 gives a single-cycle pulse
        wr(2'd1, 32'd0);
        rd(2'd1, rv); chk("len0_rb", rv, 32'd0);
        ce_base = ce_total;
        wr(2'd2, 32'h2);
        repeat (10) @(posedge clk);
        chk("len0_pulse", 32'(ce_total - ce_base), 32'd1);

        // DONE clear on the same edge as the done-set event
        wr(2'd3, 32'd0);
        rd(2'd3, rv); chk("coll_pre", rv, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd2, 32'h2);
        repeat (2) @(posedge clk);
        wr(2'd3, 32'd0);
        rd(2'd3, rv); chk("coll_set_wins", rv, 32'd1);
        repeat (8) @(posedge clk);

        // LEVEL=1 mid-pulse keeps CE high after the pulse
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h2);
        wr(2'd0, 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("level_hold_ce", 32'(ce_out), 32'd1);
        rd(2'd0, rv); chk("level_rb", rv, 32'd1);
        rd(2'd3, rv); chk("level_done", rv, 32'd1);
        wr(2'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("level_off_ce", 32'(ce_out), 32'd0);

        // Reset mid-pulse drops CE without a clock edge
        wr(2'd1, 32'd100);
        wr(2'd2, 32'h2);
        repeat (19) @(posedge clk);
        #1;
        chk("midpulse_ce", 32'(ce_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ce", 32'(ce_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, rv); chk("post_rst_busy", rv, 32'd0);
        rd(2'd1, rv); chk("post_rst_len", rv, 32'd600);
        rd(2'd0, rv); chk("post_rst_level", rv, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_ce", 32'(ce_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
